v_hier_sched: RTL
=================

V_HIER_SCHED -- requirements
Module: v_hier_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one v_hier_sub instance (legal 2..8).
REQ-002 The block SHALL have parameter LATENCY, default 2, cycles from sub_go to valid sub_qvec (legal 1..15; 0 is an elaboration error).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  input  NREQ  level request, one bit per requester.
REQ-006 The block SHALL have port req_avec  input  NREQ*4  packed operands, requester i at bits [4i+3:4i].
REQ-007 The block SHALL have port gnt  output  NREQ  one-hot grant pulse.
REQ-008 The block SHALL have port sub_avec  output  4  operand to v_hier_sub avec.
REQ-009 The block SHALL have port sub_go  output  1  one-cycle issue strobe to the sub.
REQ-010 The block SHALL have port sub_qvec  input  4  result from v_hier_sub qvec.
REQ-011 The block SHALL have ports rsp_valid (output, 1, response strobe), rsp_id (output, $clog2(NREQ), granted requester index) and rsp_qvec (output, 4, captured result).
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-014 IDLE->ISSUE SHALL occur on the edge where any req bit is 1; otherwise the FSM SHALL remain in IDLE.
REQ-015 On entering ISSUE the winner SHALL be chosen round-robin, searching upward (with wrap) from the index after the last winner.
REQ-016 In ISSUE: gnt[winner]=1, sub_go=1, and sub_avec SHALL be req_avec of the winner as sampled at entry, all for exactly one cycle.
REQ-017 sub_avec SHALL hold its value from ISSUE through RESP and SHALL be 0 in IDLE.
REQ-018 WAIT SHALL last exactly LATENCY cycles, counted by a 4-bit down-counter.
REQ-019 sub_qvec SHALL be captured on the final WAIT edge.
REQ-020 In RESP: rsp_valid=1 for one cycle; rsp_id=winner; rsp_qvec=captured value.
REQ-021 With req asserted in IDLE cycle 0: gnt/sub_go SHALL assert in cycle 1 and rsp_valid in cycle LATENCY+2.
REQ-022 RESP->ISSUE SHALL occur directly (no IDLE cycle) if any req bit is 1 in RESP; otherwise RESP->IDLE.
REQ-023 Requests arriving while busy SHALL NOT be lost; requesters SHALL hold req until gnt, and the arbiter SHALL evaluate req only at IDLE/RESP exit.
REQ-024 A requester still holding req in the cycle after its gnt SHALL be treated as a new request.
REQ-025 A req bit dropped before being granted SHALL be ignored without side effect.
REQ-026 rsp_id and rsp_qvec SHALL be 0 whenever rsp_valid=0.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE, counter=0, last-winner pointer=NREQ-1 (so requester 0 wins first), and every output to 0.
REQ-028 rst asserted mid-operation SHALL abandon the transaction with no rsp_valid, even when asserted in the RESP cycle.

Structure
REQ-029 Package v_hier_sched_pkg SHALL hold the state enum, AVEC_W=4 and QVEC_W=4.
REQ-030 Round-robin selection and pointer update SHALL live in sub-module v_hier_rr_arb (inputs req and advance; outputs one-hot gnt and index).

Verification
REQ-031 Single request: req=0001, avec0=4'hA, sub returns 4'h5 -> gnt=0001 in cycle 1; rsp_valid, rsp_id=0 and rsp_qvec=4'h5 in cycle 4 (LATENCY=2).
REQ-032 All requesters held at 1111 -> grant order 0,1,2,3,0; one RESP every LATENCY+2 cycles with no idle gap.
REQ-033 Wrap: last winner=3, req=1001 -> requester 0 is granted, then requester 3.
REQ-034 rst pulsed in a WAIT cycle -> no rsp_valid; busy=0 the next cycle; the next req=0100 is granted after the pointer reset.
REQ-035 LATENCY=1 and LATENCY=15 builds -> rsp_valid lands exactly LATENCY+2 cycles after req.
REQ-036 Requester 2 drops req before its grant while requester 1 is busy -> gnt[2] never asserts and requester 1 completes normally.

Source files
------------

// File: rtl/v_hier_sched_pkg.sv
// Shared types and widths for the hierarchical scheduler that fronts one v_hier_sub.
package v_hier_sched_pkg;

  localparam int AVEC_W = 4;
  localparam int QVEC_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/v_hier_rr_arb.sv
// Round-robin arbiter: searches upward from the slot after the last winner, wrapping.
module v_hier_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] r_last;
  logic             w_hi_found;
  logic             w_lo_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Lowest requester above the pointer wins; otherwise lowest at or below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(r_last))) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IDX_W'(i);
      end else if (req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDX_W'(i);
      end else begin
        w_hi_found = w_hi_found;
      end
    end
  end

  // One-hot grant and binary index of the selected requester.
  always_comb begin
    if (w_hi_found) begin
      index = w_hi_idx;
      gnt   = {{(NREQ-1){1'b0}}, 1'b1} << w_hi_idx;
    end else if (w_lo_found) begin
      index = w_lo_idx;
      gnt   = {{(NREQ-1){1'b0}}, 1'b1} << w_lo_idx;
    end else begin
      index = '0;
      gnt   = '0;
    end
  end

  // Last-winner pointer; reset value makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDX_W'(NREQ - 1);
    end else if (advance && (w_hi_found || w_lo_found)) begin
      r_last <= index;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/v_hier_sched.sv
// Shares one fixed-latency v_hier_sub among NREQ requesters: arbitrate, issue, wait, respond.
module v_hier_sched
  import v_hier_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AVEC_W-1:0]  req_avec,
  output logic [NREQ-1:0]         gnt,
  output logic [AVEC_W-1:0]       sub_avec,
  output logic                    sub_go,
  input  logic [QVEC_W-1:0]       sub_qvec,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [QVEC_W-1:0]       rsp_qvec,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NREQ);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("v_hier_sched: LATENCY must be in 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("v_hier_sched: NREQ must be in 2..8");
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_win;
  logic [NREQ-1:0]   r_gnt;
  logic              r_sub_go;
  logic [AVEC_W-1:0] r_sub_avec;
  logic              r_rsp_valid;
  logic [IDX_W-1:0]  r_rsp_id;
  logic [QVEC_W-1:0] r_rsp_qvec;
  logic              r_busy;

  logic              w_any;
  logic              w_advance;
  logic [NREQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]  w_arb_index;
  logic [AVEC_W-1:0] w_win_avec;

  assign w_any     = |req;
  assign w_advance = ((r_state == IDLE) || (r_state == RESP)) && w_any;

  v_hier_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (w_advance),
    .gnt     (w_arb_gnt),
    .index   (w_arb_index)
  );

  // Operand of the requester the arbiter is currently selecting.
  always_comb begin
    w_win_avec = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_index == IDX_W'(i)) begin
        w_win_avec = req_avec[i*AVEC_W +: AVEC_W];
      end else begin
        w_win_avec = w_win_avec;
      end
    end
  end

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_win       <= '0;
      r_gnt       <= '0;
      r_sub_go    <= 1'b0;
      r_sub_avec  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_qvec  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_id    <= '0;
          r_rsp_qvec  <= '0;
          if (w_any) begin
            r_state    <= ISSUE;
            r_win      <= w_arb_index;
            r_gnt      <= w_arb_gnt;
            r_sub_go   <= 1'b1;
            r_sub_avec <= w_win_avec;
            r_busy     <= 1'b1;
          end else begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_sub_go   <= 1'b0;
            r_sub_avec <= '0;
            r_busy     <= 1'b0;
          end
        end
        ISSUE: begin
          r_state  <= WAIT;
          r_gnt    <= '0;
          r_sub_go <= 1'b0;
          r_cnt    <= CNT_W'(LATENCY - 1);
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_win;
            r_rsp_qvec  <= sub_qvec;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_gnt       <= '0;
          r_sub_go    <= 1'b0;
          r_sub_avec  <= '0;
          r_rsp_valid <= 1'b0;
          r_rsp_id    <= '0;
          r_rsp_qvec  <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign sub_go   = r_sub_go;
  assign sub_avec = r_sub_avec;
  assign busy     = r_busy;

  // A reset landing in the RESP cycle must suppress the response already on the wires.
  assign rsp_valid = r_rsp_valid & ~rst;
  assign rsp_id    = rst ? '0 : r_rsp_id;
  assign rsp_qvec  = rst ? '0 : r_rsp_qvec;

endmodule
